board_ram_arbiter: RTL and testbench

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

---
 rtl/board_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_board_ram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port-style board RAM.
// Clears the board cells after reset or on request, then serves one access per three cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// CLR    | writing zero to cells 0..BOARD_CELLS-1, one per cycle (busy)
// IDLE   | waiting for clear_start or a request; arbitration happens here
// ACCESS | registered access presented to the RAM for one cycle
// RESP   | ack pulse to the granted requester with rdata/err
module board_ram_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_DEPTH   = 256,
   parameter int BOARD_CELLS = 9
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   input  logic              clear_start,
   output logic              busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int CNT_W = (BOARD_CELLS > 1) ? $clog2(BOARD_CELLS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BOARD_CELLS - 1);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(MEM_DEPTH);

   typedef enum logic [1:0] {CLR, IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  clr_cnt, clr_cnt_nxt;
   logic              last_grant;
   logic              grant_id;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;

   logic              grant;
   logic              pick1;
   logic [ADDR_W-1:0] win_addr;
   logic              win_oob;
   logic              ram_we_c;

   // last_grant=1 means requester 1 was served last, so requester 0 wins a tie
   assign pick1    = req1 & (~req0 | ~last_grant);
   assign win_addr = pick1 ? addr1 : addr0;
   assign win_oob  = ({1'b0, win_addr} >= DEPTH_V);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLR;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         if (grant) begin
            last_grant <= pick1;
            grant_id   <= pick1;
            we_q       <= pick1 ? we1 : we0;
            addr_q     <= win_addr;
            wdata_q    <= pick1 ? wdata1 : wdata0;
            err_q      <= win_oob;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      grant       = 1'b0;
      case (state)
         CLR: begin
            if (clr_cnt == CNT_LAST) begin
               state_nxt   = IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (clear_start) begin
               state_nxt   = CLR;
               clr_cnt_nxt = '0;
            end else if (req0 | req1) begin
               grant     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = CLR;
      endcase
   end

   always_comb begin
      ram_we_c = 1'b0;
      if (state == CLR)
         ram_we_c = 1'b1;
      else if (state == ACCESS)
         ram_we_c = we_q & ~err_q;
   end

   // state is held in CLR during reset, so the write strobe must be masked explicitly
   assign ram_we    = ram_we_c & reset_n;
   assign busy      = (state == CLR);
   assign ram_waddr = (state == CLR) ? ADDR_W'(clr_cnt) : addr_q;
   assign ram_raddr = addr_q;
   assign ram_din   = (state == CLR) ? '0 : wdata_q;

   assign ack0  = (state == RESP) & ~grant_id;
   assign ack1  = (state == RESP) &  grant_id;
   assign err   = (state == RESP) &  err_q;
   assign rdata = ((state == RESP) && !we_q && !err_q) ? ram_dout : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Scoreboard bench for board_ram_arbiter: behavioural RAM, shadow memory model,
// per-requester expectation queues drained by an independent monitor.
module tb_board_ram_arbiter;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 256;
   localparam int CELLS = 9;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          clear_start = 1'b0;
   logic          ack0, ack1, err, busy, ram_we;
   logic [DW-1:0] rdata, ram_din;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_dout = '0;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          q0[$];
   exp_t          q1[$];
   int            ack_log[$];
   logic [DW-1:0] mem[DEPTH];
   logic [DW-1:0] shadow[DEPTH];
   int            errors = 0;
   int            checks = 0;
   int            clr_idx = 0;
   int            clr_runs = 0;
   int            we_pulses = 0;
   int            last_ack = 1;
   bit            prev_busy = 1'b0;

   board_ram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .BOARD_CELLS(CELLS)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
      .clear_start(clear_start), .busy(busy),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ram_model();
      logic [DW-1:0] rd;
      forever begin
         @(posedge clock);
         rd = mem[ram_raddr[7:0]];
         if (ram_we) mem[ram_waddr[7:0]] = ram_din;
         ram_dout <= rd;
      end
   endtask

   task automatic monitor();
      int   id;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            clr_idx   = 0;
            prev_busy = 1'b0;
            last_ack  = 1;
         end else begin
            if (busy) begin
               chk("clr_we", ram_we, 1);
               chk("clr_din", ram_din, 0);
               chk("clr_addr", ram_waddr, clr_idx);
               clr_idx++;
            end else if (prev_busy) begin
               chk("clr_len", clr_idx, CELLS);
               clr_idx = 0;
               clr_runs++;
            end
            if (ram_we && !busy) begin
               we_pulses++;
               chk("we_in_range", ram_waddr < DEPTH, 1);
            end
            chk("ack_exclusive", ack0 & ack1, 0);
            if (ack0 || ack1) begin
               id = ack1 ? 1 : 0;
               if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_ack%0d: got ack expected none", id);
               end else begin
                  e = (id == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("rdata%0d", id), rdata, e.rdata);
                  chk($sformatf("err%0d", id), err, e.err);
               end
               ack_log.push_back(id);
               last_ack = id;
            end else begin
               chk("err_without_ack", err, 0);
            end
            prev_busy = busy;
         end
      end
   endtask

   task automatic watchdog();
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   endtask

   // Must be called at a falling edge; computes the expected response from the shadow memory.
   task automatic issue(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.err   = (a >= DEPTH);
      e.rdata = (!we && !e.err) ? shadow[a[7:0]] : '0;
      if (we && !e.err) shadow[a[7:0]] = d;
      if (id == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; q0.push_back(e);
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; q1.push_back(e);
      end
   endtask

   task automatic wait_ack(input int id, output int n);
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clock);
         n++;
         seen = (id == 0) ? ack0 : ack1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack%0d_timeout: got no ack expected ack within 100 cycles", id);
      end
   endtask

   task automatic drop(input int id);
      if (id == 0) req0 = 1'b0;
      else         req1 = 1'b0;
   endtask

   task automatic held(input int id, input int n);
      int            cyc;
      logic [AW-1:0] a;
      for (int k = 0; k < n; k++) begin
         a = (id == 0) ? AW'($urandom_range(16, 127)) : AW'($urandom_range(128, 255));
         issue(id, 1'($urandom_range(0, 1)), a, DW'($urandom));
         wait_ack(id, cyc);
      end
      drop(id);
   endtask

   task automatic rand_driver(input int id, input int n);
      int            cyc;
      logic          we;
      logic [AW-1:0] a;
      for (int k = 0; k < n; k++) begin
         we = 1'($urandom_range(0, 1));
         if (id == 0)
            a = AW'($urandom_range(0, 127));
         else if ($urandom_range(0, 7) == 0)
            a = AW'($urandom_range(256, 65535));
         else
            a = AW'($urandom_range(128, 255));
         issue(id, we, a, DW'($urandom));
         wait_ack(id, cyc);
         drop(id);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
   endtask

   initial begin
      int n;
      int runs0;
      int we0_cnt;
      int first;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]    = DW'($urandom);
         shadow[i] = mem[i];
      end
      fork
         monitor();
         ram_model();
         watchdog();
      join_none

      // outputs held quiet during reset
      repeat (3) @(negedge clock);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_err", err, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_rdata", rdata, 0);

      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < CELLS; i++) shadow[i] = '0;
      repeat (12) @(negedge clock);
      chk("clear_after_reset", clr_runs, 1);
      chk("idle_not_busy", busy, 0);

      // write then read back, two-cycle latency from the idle cycle
      issue(0, 1'b1, 16'd4, 16'h0001);
      wait_ack(0, n);
      chk("lat_write", n, 2);
      drop(0);
      @(negedge clock);
      issue(0, 1'b0, 16'd4, 16'h0000);
      wait_ack(0, n);
      chk("lat_read", n, 2);
      drop(0);

      // out-of-range write must not reach the RAM; boundary addresses
      @(negedge clock);
      we0_cnt = we_pulses;
      issue(1, 1'b1, 16'h0100, 16'h5A5A);
      wait_ack(1, n);
      drop(1);
      chk("oob_no_ram_we", we_pulses, we0_cnt);
      @(negedge clock);
      issue(0, 1'b0, 16'h0000, 16'h0000);
      wait_ack(0, n);
      drop(0);
      @(negedge clock);
      issue(1, 1'b1, 16'h00FF, 16'h1234);
      wait_ack(1, n);
      drop(1);
      @(negedge clock);
      issue(1, 1'b0, 16'h00FF, 16'h0000);
      wait_ack(1, n);
      drop(1);
      @(negedge clock);
      issue(1, 1'b0, 16'hFFFF, 16'h0000);
      wait_ack(1, n);
      drop(1);

      // both held high: grants alternate starting with the one not served last
      @(negedge clock);
      ack_log.delete();
      first = (last_ack == 0) ? 1 : 0;
      fork
         held(0, 4);
         held(1, 4);
      join
      chk("rr_count", ack_log.size(), 8);
      for (int k = 0; k < 8 && k < ack_log.size(); k++)
         chk($sformatf("rr_order_%0d", k), ack_log[k], (first + k) % 2);

      // clear_start during ACCESS/RESP is ignored
      @(negedge clock);
      runs0 = clr_runs;
      issue(0, 1'b1, 16'd3, 16'hBEEF);
      @(negedge clock);
      clear_start = 1'b1;
      @(negedge clock);
      chk("ack_with_clear_ignored", ack0, 1);
      drop(0);
      @(negedge clock);
      clear_start = 1'b0;
      repeat (3) @(negedge clock);
      chk("clear_ignored", clr_runs, runs0);

      // clear_start in IDLE beats a pending request
      clear_start = 1'b1;
      for (int i = 0; i < CELLS; i++) shadow[i] = '0;
      issue(0, 1'b0, 16'd3, 16'h0000);
      @(negedge clock);
      clear_start = 1'b0;
      wait_ack(0, n);
      chk("clear_then_grant", n + 1, 12);
      chk("clear_ran", clr_runs, runs0 + 1);
      drop(0);

      // reset in ACCESS aborts without ack and restarts the clear
      @(negedge clock);
      issue(0, 1'b0, 16'd5, 16'h0000);
      @(posedge clock);
      #1 reset_n = 1'b0;
      @(negedge clock);
      chk("abort_no_ack0", ack0, 0);
      @(negedge clock);
      chk("abort_no_ack0_b", ack0, 0);
      drop(0);
      q0.delete();
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < CELLS; i++) shadow[i] = '0;
      runs0 = clr_runs;
      repeat (10) @(negedge clock);
      chk("clear_after_abort", clr_runs, runs0 + 1);
      ack_log.delete();
      fork
         held(0, 1);
         held(1, 1);
      join
      chk("post_reset_count", ack_log.size(), 2);
      if (ack_log.size() == 2) begin
         chk("post_reset_first", ack_log[0], 0);
         chk("post_reset_second", ack_log[1], 1);
      end

      // randomized traffic from both requesters in disjoint address regions
      @(negedge clock);
      fork
         rand_driver(0, 30);
         rand_driver(1, 30);
      join
      repeat (5) @(negedge clock);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
